cp0_exc_handler: RTL and testbench
==================================

// Module: cp0_exc_handler
// PURPOSE
//  Consumes exception codes produced by the per-stage exception detector, carried down the pipe to M.
//  Holds CP0 state: BadVAddr, Count, Compare, Status, Cause, EPC.
//  Prioritises interrupts over M-stage exceptions, commits CP0 state and issues flush plus redirect PC.
//  Also serves MFC0/MTC0 and ERET.
// PARAMETERS
//  EXC_VECTOR  32'hBFC0_0380  exception entry PC (BEV=1)
//  CNT_DIV     2              Count increments once every CNT_DIV clocks
// PORTS
//  clk           in   1   clock; all state updates on rising edge
//  reset         in   1   synchronous, active-high reset
//  inst_valid_M  in   1   M stage holds a real (non-bubble) instruction
//  exc_M         in   5   exception code carried to M; 0 = none
//  pc_M          in   32  PC of the M instruction
//  bd_M          in   1   M instruction sits in a branch delay slot
//  badvaddr_M    in   32  faulting address for AdEL/AdES (fetch PC or data address)
//  eret_M        in   1   M instruction is ERET
//  mtc0_we_M     in   1   MTC0 write request
//  cp0_addr_M    in   5   CP0 register number, for read and write; sel is always 0
//  cp0_wdata_M   in   32  MTC0 data
//  ext_int       in   6   hardware interrupt lines HW5..HW0, level-sensitive
//  cp0_rdata_M   out  32  MFC0 data (combinational from current state); 0 for unimplemented numbers
//  flush         out  1   kill M and all younger stages this cycle
//  redirect_pc   out  32  next fetch PC, valid when flush=1
//  epc_o         out  32  current EPC
// BEHAVIOUR
//  Reset values
//   Status=32'h0040_0000 (BEV=1, EXL=0, IE=0, IM=0); all other registers 0; div counter 0.
//   After reset: flush=0, redirect_pc=0.
//  Register map (number / writable fields)
//   BadVAddr 8 / read-only.  Count 9 / all bits.  Compare 11 / all bits.
//   Status 12 / IM[15:8], EXL[1], IE[0].  Cause 13 / IP[9:8] only.  EPC 14 / all bits.
//  Cause fields: BD[31], TI[30], IP[15:10] = {ext_int[5] | TI, ext_int[4:0]} sampled every cycle,
//   IP[9:8] software, ExcCode[6:2].
//  Interrupt pending (int_req) = IE & ~EXL & |(Cause.IP & Status.IM) & inst_valid_M.
//  Priority in M: int_req > exc_M!=0 > eret_M > mtc0_we_M. Only the highest-priority action takes effect.
//  Exception entry (int_req or exc_M!=0)
//   Same cycle: flush=1, redirect_pc=EXC_VECTOR.
//   Next edge: ExcCode = int_req ? 5'd0 : exc_M.
//   Next edge, only if EXL was 0: EPC = bd_M ? pc_M-4 : pc_M; BD = bd_M.
//   Next edge: EXL=1.
//   For AdEL/AdES: BadVAddr = badvaddr_M.
//   MTC0 on the faulting instruction is suppressed.
//  ERET with no exception: flush=1, redirect_pc=EPC (including a same-cycle-forwarded value is NOT done), EXL=0 next edge.
//  MTC0 with no higher action: write at next edge.
//   Write to Compare clears TI.
//   Write to Count loads Count, resets the div counter, and overrides the increment that cycle.
//  Timer
//   Count += 1 when div counter == CNT_DIV-1; Count wraps 32'hFFFF_FFFF->0.
//   TI set (sticky) the edge after Count==Compare, unless Compare is written that cycle (the write wins).
//  Bubbles: inst_valid_M=0 blocks interrupts; exc_M of a bubble is 0 by pipeline contract.
//  flush and redirect_pc are combinational; all CP0 state is registered.
//  reset overrides everything in flight, including a same-cycle exception.
// CONFIGURATION
//  CP0_TIMER_EN defined
//   Count/Compare/TI and the cp0_timer instance exist as above.
//  CP0_TIMER_EN undefined
//   Reg 9 and reg 11 read 0 and ignore writes; TI is constant 0; Cause.IP[15] = ext_int[5] only.
// STRUCTURE
//  cpu_def.vh
//   Exception codes: Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12.
//   CP0 register numbers; Status/Cause bit positions; EXC_VECTOR default.
//  Sub-module cp0_timer: Count, div counter, Compare, TI.
//   Instantiated only under CP0_TIMER_EN.
// TESTING
//  1. exc_M=Ov (12), pc_M=0x80001000, bd_M=0
//     -> flush=1, redirect_pc=0xBFC00380; next cycle EPC=0x80001000, ExcCode=12, EXL=1.
//  2. exc_M=AdEL (4), bd_M=1, pc_M=0x80002004, badvaddr_M=0x80002006
//     -> EPC=0x80002000, BD=1, BadVAddr=0x80002006.
//  3. Status=0x0040_0401 (IM2, IE); ext_int[0]=1; exc_M=Sys on same cycle
//     -> ExcCode=0 (interrupt wins); second exception with EXL=1 leaves EPC unchanged.
//  4. ERET with EPC=0x80003000
//     -> flush=1, redirect_pc=0x80003000; EXL=0 next edge.
//     MTC0 Cause 0x300 -> Cause reads 0x300.
//  5. CP0_TIMER_EN defined: MTC0 Count=0, Compare=3
//     -> TI=1 after 6..7 clocks; MTC0 Compare clears TI.
//     Undefined: MFC0 reg 9 returns 0.
//  6. Assert reset during a flush cycle
//     -> Status=0x0040_0000; all other registers 0; flush=0 next cycle.

Source files
------------

// File: rtl/cp0_exc_handler_pkg.sv
// CP0 definitions shared by the exception handler and its timer:
// exception codes, register numbers, status/cause bit positions, entry vector.
package cp0_exc_handler_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int ST_BEV = 22;
  localparam int CA_TI  = 30;
  localparam int CA_BD  = 31;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  // Single action selected in M after priority resolution
  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_EXC,
    ACT_ERET,
    ACT_MTC0
  } act_e;

endpackage

// File: rtl/cp0_exc_handler_timer.sv
// CP0 timer: Count with a clock divider, Compare, and the sticky TI flag.
// Only instantiated when CP0_TIMER_EN is defined.
module cp0_timer
  import cp0_exc_handler_pkg::*;
#(
  parameter int CNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cnt_we,
  input  logic        cmp_we,
  input  logic [31:0] wdata,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  localparam int DW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CNT_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic          ti_q, ti_d;

  // Divider tick, software loads, and TI set/clear (a Compare write beats a match)
  always_comb begin
    div_d     = div_q;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q | (count_q == compare_q);
    if (div_q == DIV_LAST) begin
      div_d   = '0;
      count_d = count_q + 32'd1;
    end else begin
      div_d = div_q + DW'(1);
    end
    if (cnt_we) begin
      div_d   = '0;
      count_d = wdata;
    end
    if (cmp_we) begin
      compare_d = wdata;
      ti_d      = 1'b0;
    end
  end

  // Timer state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_exc_handler.sv
// CP0 exception handler: interrupt/exception priority in M, CP0 register
// file, MFC0/MTC0, ERET, flush and redirect.
// Optional timer (Count/Compare/TI) built only when CP0_TIMER_EN is defined.
module cp0_exc_handler
  import cp0_exc_handler_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int          CNT_DIV    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_valid_M,
  input  logic [4:0]  exc_M,
  input  logic [31:0] pc_M,
  input  logic        bd_M,
  input  logic [31:0] badvaddr_M,
  input  logic        eret_M,
  input  logic        mtc0_we_M,
  input  logic [4:0]  cp0_addr_M,
  input  logic [31:0] cp0_wdata_M,
  input  logic [5:0]  ext_int,
  output logic [31:0] cp0_rdata_M,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [31:0] epc_o
);

  logic [31:0] badvaddr_q, badvaddr_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d;

  logic [31:0] count, compare;
  logic        ti;
  logic        int_req;
  act_e        act;
  logic [31:0] status_r, cause_r;

`ifdef CP0_TIMER_EN
  logic cnt_we, cmp_we;
  assign cnt_we = (act == ACT_MTC0) && (cp0_addr_M == CP0_COUNT);
  assign cmp_we = (act == ACT_MTC0) && (cp0_addr_M == CP0_COMPARE);

  cp0_timer #(.CNT_DIV(CNT_DIV)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .cnt_we    (cnt_we),
    .cmp_we    (cmp_we),
    .wdata     (cp0_wdata_M),
    .count_o   (count),
    .compare_o (compare),
    .ti_o      (ti)
  );
`else
  assign count   = '0;
  assign compare = '0;
  assign ti      = 1'b0;
`endif

  // Priority resolution: interrupt > exception > ERET > MTC0
  always_comb begin
    int_req = ie_q & ~exl_q & (|({ip_hw_q, ip_sw_q} & im_q)) & inst_valid_M;
    if (int_req || exc_M != 5'd0) act = ACT_EXC;
    else if (eret_M)              act = ACT_ERET;
    else if (mtc0_we_M)           act = ACT_MTC0;
    else                          act = ACT_NONE;
  end

  // Flush/redirect are combinational; reset squashes any in-flight action
  always_comb begin
    flush       = 1'b0;
    redirect_pc = '0;
    if (!reset) begin
      if (act == ACT_EXC) begin
        flush       = 1'b1;
        redirect_pc = EXC_VECTOR;
      end else if (act == ACT_ERET) begin
        flush       = 1'b1;
        redirect_pc = epc_q;
      end
    end
  end

  // Next CP0 state for the winning action; HW IP lines sampled every cycle
  always_comb begin
    badvaddr_d = badvaddr_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;
    epc_d      = epc_q;
    ip_hw_d    = {ext_int[5] | ti, ext_int[4:0]};
    unique case (act)
      ACT_EXC: begin
        exccode_d = int_req ? EXC_INT : exc_M;
        exl_d     = 1'b1;
        // Nested exceptions keep the original EPC/BD
        if (!exl_q) begin
          epc_d = bd_M ? (pc_M - 32'd4) : pc_M;
          bd_d  = bd_M;
        end
        if (!int_req && (exc_M == EXC_ADEL || exc_M == EXC_ADES))
          badvaddr_d = badvaddr_M;
      end
      ACT_ERET: exl_d = 1'b0;
      ACT_MTC0: begin
        unique case (cp0_addr_M)
          CP0_STATUS: begin
            im_d  = cp0_wdata_M[15:8];
            exl_d = cp0_wdata_M[ST_EXL];
            ie_d  = cp0_wdata_M[ST_IE];
          end
          CP0_CAUSE: ip_sw_d = cp0_wdata_M[9:8];
          CP0_EPC:   epc_d   = cp0_wdata_M;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // CP0 state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      badvaddr_q <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_hw_q    <= '0;
      ip_sw_q    <= '0;
      exccode_q  <= '0;
      epc_q      <= '0;
    end else begin
      badvaddr_q <= badvaddr_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      exccode_q  <= exccode_d;
      epc_q      <= epc_d;
    end
  end

  // MFC0 read mux; BEV is hard-wired to 1
  always_comb begin
    status_r = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
    cause_r  = {bd_q, ti, 14'd0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b00};
    unique case (cp0_addr_M)
      CP0_BADVADDR: cp0_rdata_M = badvaddr_q;
      CP0_COUNT:    cp0_rdata_M = count;
      CP0_COMPARE:  cp0_rdata_M = compare;
      CP0_STATUS:   cp0_rdata_M = status_r;
      CP0_CAUSE:    cp0_rdata_M = cause_r;
      CP0_EPC:      cp0_rdata_M = epc_q;
      default:      cp0_rdata_M = '0;
    endcase
  end

  assign epc_o = epc_q;

endmodule

// File: tb/tb_cp0_exc_handler.sv
// Bench for cp0_exc_handler: directed scenarios then random traffic, all
// checked against a behavioural CP0 model (timer part follows CP0_TIMER_EN).
`timescale 1ns/1ps
module tb_cp0_exc_handler;

  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam int DIV = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_valid_M;
  logic [4:0]  exc_M;
  logic [31:0] pc_M;
  logic        bd_M;
  logic [31:0] badvaddr_M;
  logic        eret_M;
  logic        mtc0_we_M;
  logic [4:0]  cp0_addr_M;
  logic [31:0] cp0_wdata_M;
  logic [5:0]  ext_int;
  logic [31:0] cp0_rdata_M;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] epc_o;

  int checks = 0;
  int errors = 0;

  cp0_exc_handler #(.EXC_VECTOR(VEC), .CNT_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .inst_valid_M(inst_valid_M), .exc_M(exc_M),
    .pc_M(pc_M), .bd_M(bd_M), .badvaddr_M(badvaddr_M), .eret_M(eret_M),
    .mtc0_we_M(mtc0_we_M), .cp0_addr_M(cp0_addr_M), .cp0_wdata_M(cp0_wdata_M),
    .ext_int(ext_int), .cp0_rdata_M(cp0_rdata_M), .flush(flush),
    .redirect_pc(redirect_pc), .epc_o(epc_o)
  );

  always #10 clk = ~clk;

  // Behavioural model of architectural CP0 state
  logic [31:0] m_badv, m_epc, m_count, m_cmp;
  logic [7:0]  m_im;
  logic [5:0]  m_iphw;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_exc;
  logic        m_exl, m_ie, m_bd, m_ti;
  int          m_div;

  task automatic model_reset();
    m_badv = 0; m_epc = 0; m_count = 0; m_cmp = 0; m_im = 0; m_iphw = 0;
    m_ipsw = 0; m_exc = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_div = 0;
  endtask

  function automatic logic model_int();
    return m_ie && !m_exl && (({m_iphw, m_ipsw} & m_im) != 0) && inst_valid_M;
  endfunction

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    case (a)
      5'd8:  return m_badv;
      5'd9:  return m_count;
      5'd11: return m_cmp;
      5'd12: return 32'h0040_0000 + (32'(m_im) << 8) + (32'(m_exl) << 1) + 32'(m_ie);
      5'd13: return (32'(m_bd) << 31) + (32'(m_ti) << 30) + (32'(m_iphw) << 10)
                  + (32'(m_ipsw) << 8) + (32'(m_exc) << 2);
      5'd14: return m_epc;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    logic ti_int, ti_next, take_exc;
    if (reset) begin model_reset(); return; end
    ti_int   = model_int();
    take_exc = ti_int || exc_M != 0;
    ti_next  = m_ti;
`ifdef CP0_TIMER_EN
    if (m_count == m_cmp) ti_next = 1'b1;
    m_div = (m_div + 1) % DIV;
    if (m_div == 0) m_count = m_count + 1;
`endif
    m_iphw = {ext_int[5] | m_ti, ext_int[4:0]};
    if (take_exc) begin
      m_exc = ti_int ? 5'd0 : exc_M;
      if (!m_exl) begin m_epc = bd_M ? pc_M - 4 : pc_M; m_bd = bd_M; end
      m_exl = 1'b1;
      if (!ti_int && (exc_M == 5'd4 || exc_M == 5'd5)) m_badv = badvaddr_M;
    end else if (eret_M) begin
      m_exl = 1'b0;
    end else if (mtc0_we_M) begin
      case (cp0_addr_M)
`ifdef CP0_TIMER_EN
        5'd9:  begin m_count = cp0_wdata_M; m_div = 0; end
        5'd11: begin m_cmp = cp0_wdata_M; ti_next = 1'b0; end
`endif
        5'd12: begin m_im = cp0_wdata_M[15:8]; m_exl = cp0_wdata_M[1]; m_ie = cp0_wdata_M[0]; end
        5'd13: m_ipsw = cp0_wdata_M[9:8];
        5'd14: m_epc = cp0_wdata_M;
        default: ;
      endcase
    end
    m_ti = ti_next;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset = 0; inst_valid_M = 0; exc_M = 0; pc_M = 0; bd_M = 0; badvaddr_M = 0;
    eret_M = 0; mtc0_we_M = 0; cp0_addr_M = 0; cp0_wdata_M = 0;
  endtask

  // One clock: check combinational outputs, advance model, move to next negedge
  task automatic cycle();
    logic ef, take_exc;
    logic [31:0] er;
    #1;
    take_exc = model_int() || exc_M != 0;
    ef = !reset && (take_exc || eret_M);
    er = !ef ? 32'd0 : (take_exc ? VEC : m_epc);
    chk("flush", {31'd0, flush}, {31'd0, ef});
    chk("redirect_pc", redirect_pc, er);
    chk("rdata", cp0_rdata_M, model_rd(cp0_addr_M));
    chk("epc_o", epc_o, m_epc);
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Read every register number with no action in flight (no clock edge)
  task automatic sweep();
    logic [4:0] regs [7];
    regs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
    idle();
    for (int i = 0; i < 7; i++) begin
      cp0_addr_M = regs[i];
      #0.5;
      chk($sformatf("reg%0d", regs[i]), cp0_rdata_M, model_rd(regs[i]));
    end
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle(); inst_valid_M = 1; mtc0_we_M = 1; cp0_addr_M = a; cp0_wdata_M = d;
    cycle();
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    idle(); cp0_addr_M = a; #0.5; d = cp0_rdata_M;
  endtask

  initial begin
    logic [31:0] v;
    logic [4:0] codes [7];
    logic [4:0] addrs [7];
    codes = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};
    addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
    model_reset();
    idle(); ext_int = 0; reset = 1;
    @(negedge clk);
    cycle(); reset = 1; cycle();
    idle();
    // Reset state
    rd(5'd12, v); chk("rst_status", v, 32'h0040_0000);
    rd(5'd14, v); chk("rst_epc", v, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);
    sweep();

    // 1: overflow exception
    idle(); inst_valid_M = 1; exc_M = 5'd12; pc_M = 32'h8000_1000;
    #0.5; chk("t1_flush", {31'd0, flush}, 32'd1); chk("t1_redirect", redirect_pc, 32'hBFC0_0380);
    cycle();
    rd(5'd14, v); chk("t1_epc", v, 32'h8000_1000);
    rd(5'd13, v); chk("t1_exccode", (v >> 2) & 32'h1F, 32'd12);
    rd(5'd12, v); chk("t1_exl", (v >> 1) & 1, 32'd1);
    sweep();

    // 2: AdEL in a delay slot
    mtc0(5'd12, 32'h0040_0000);
    idle(); inst_valid_M = 1; exc_M = 5'd4; bd_M = 1; pc_M = 32'h8000_2004;
    badvaddr_M = 32'h8000_2006;
    cycle();
    rd(5'd14, v); chk("t2_epc", v, 32'h8000_2000);
    rd(5'd13, v); chk("t2_bd", v >> 31, 32'd1);
    rd(5'd8, v);  chk("t2_badvaddr", v, 32'h8000_2006);

    // 3: interrupt beats a same-cycle syscall; nested exception keeps EPC
    mtc0(5'd12, 32'h0040_0401);
    idle(); ext_int = 6'd1; cycle();
    idle(); inst_valid_M = 1; exc_M = 5'd8; pc_M = 32'h8000_4000;
    cycle();
    rd(5'd13, v); chk("t3_exccode", (v >> 2) & 32'h1F, 32'd0);
    rd(5'd14, v); chk("t3_epc", v, 32'h8000_4000);
    idle(); inst_valid_M = 1; exc_M = 5'd12; pc_M = 32'h8000_5000;
    cycle();
    rd(5'd14, v); chk("t3_epc_kept", v, 32'h8000_4000);
    ext_int = 0; idle(); cycle();

    // 4: ERET and software interrupt bits
    mtc0(5'd14, 32'h8000_3000);
    idle(); inst_valid_M = 1; eret_M = 1;
    #0.5; chk("t4_flush", {31'd0, flush}, 32'd1); chk("t4_redirect", redirect_pc, 32'h8000_3000);
    cycle();
    rd(5'd12, v); chk("t4_exl", (v >> 1) & 1, 32'd0);
    mtc0(5'd13, 32'h0000_0300);
    rd(5'd13, v); chk("t4_cause_ip", v & 32'h300, 32'h300);
    sweep();

    // 5: timer
`ifdef CP0_TIMER_EN
    mtc0(5'd11, 32'd3);
    mtc0(5'd9, 32'd0);
    for (int i = 0; i < 8; i++) begin idle(); cycle(); end
    rd(5'd13, v); chk("t5_ti_set", (v >> 30) & 1, 32'd1);
    mtc0(5'd11, 32'd3);
    rd(5'd13, v); chk("t5_ti_clr", (v >> 30) & 1, 32'd0);
`else
    mtc0(5'd9, 32'd5);
    rd(5'd9, v); chk("t5_count_zero", v, 32'd0);
    mtc0(5'd11, 32'd7);
    rd(5'd11, v); chk("t5_compare_zero", v, 32'd0);
`endif
    sweep();

    // 6: reset during a flush cycle
    idle(); inst_valid_M = 1; exc_M = 5'd12; pc_M = 32'h8000_6000; reset = 1;
    cycle();
    idle();
    chk("t6_flush", {31'd0, flush}, 32'd0);
    rd(5'd12, v); chk("t6_status", v, 32'h0040_0000);
    rd(5'd14, v); chk("t6_epc", v, 32'd0);
    sweep();

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      if (n % 16 == 0) sweep();
      idle();
      inst_valid_M = $urandom_range(0, 3) != 0;
      if (inst_valid_M && $urandom_range(0, 9) == 0) exc_M = codes[$urandom_range(0, 6)];
      pc_M        = $urandom & 32'hFFFF_FFFC;
      bd_M        = 1'($urandom);
      badvaddr_M  = $urandom;
      eret_M      = $urandom_range(0, 11) == 0;
      mtc0_we_M   = $urandom_range(0, 3) == 0;
      cp0_addr_M  = addrs[$urandom_range(0, 6)];
      cp0_wdata_M = $urandom;
      ext_int     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      reset       = $urandom_range(0, 99) == 0;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
